// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, branch-counter encodings and the IF-stage branch
// classifier used by the branch predictor.
package mips_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic is_branch(input logic [31:0] instr);
    logic br;
    br = 1'b0;
    case (instr[31:26])
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: br = 1'b1;
      OP_REGIMM: br = (instr[20:16] == RT_BLTZ) || (instr[20:16] == RT_BGEZ);
      default: br = 1'b0;
    endcase
    return br;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of 2-bit saturating branch counters: one async read port, one
// synchronous training port, all entries loaded with init_state on reset.
module sat_counter_table
  import mips_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = WNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0] ctr [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_STATE;
    end else if (wr_en) begin
      if (wr_taken && ctr[wr_idx] != ST)
        ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
      else if (!wr_taken && ctr[wr_idx] != SNT)
        ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
    end
  end

  // Reads see the pre-update value when they hit the entry being trained.
  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor with ID-stage resolve/train and mispredict
// redirect. Define BRANCH_PRED_STATS_EN to add resolved/mispredict counters.
module branch_predictor
  import mips_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_Instruction,
  input  logic        IF_ID_Write,
  input  logic        ID_Flush,
  input  logic        ID_BranchTaken,
  output logic        PredictTaken,
  output logic [31:0] PredictedPC,
  output logic        Mispredict,
`ifdef BRANCH_PRED_STATS_EN
  output logic [31:0] StatBranches,
  output logic [31:0] StatMispredicts,
`endif
  output logic [31:0] CorrectPC
);

  logic                  if_is_branch;
  logic [INDEX_BITS-1:0] if_idx;
  logic [31:0]           if_fall;
  logic [31:0]           if_target;
  logic [1:0]            if_ctr;

  logic                  id_valid;
  logic                  id_pred;
  logic [INDEX_BITS-1:0] id_idx;
  logic [31:0]           id_target;
  logic [31:0]           id_fall;
  logic                  resolve;

  assign if_is_branch = is_branch(IF_Instruction);
  assign if_idx       = IF_PC[INDEX_BITS+1:2];
  assign if_fall      = IF_PC + 32'd4;
  assign if_target    = if_fall + {{14{IF_Instruction[15]}}, IF_Instruction[15:0], 2'b00};

  sat_counter_table #(
    .INDEX_BITS(INDEX_BITS),
    .INIT_STATE(INIT_STATE)
  ) u_table (
    .clk      (Clk),
    .rst      (Rst),
    .rd_idx   (if_idx),
    .rd_ctr   (if_ctr),
    .wr_en    (resolve),
    .wr_idx   (id_idx),
    .wr_taken (ID_BranchTaken)
  );

  // Outputs are gated by Rst so the first reset cycle is quiet even though the
  // table and ID register only clear at the edge.
  assign PredictTaken = if_is_branch & if_ctr[1] & ~Rst;
  assign PredictedPC  = PredictTaken ? if_target : if_fall;

  assign resolve    = id_valid & IF_ID_Write & ~Rst;
  assign Mispredict = resolve & (id_pred != ID_BranchTaken);
  assign CorrectPC  = (Mispredict & ID_BranchTaken) ? id_target : id_fall;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      id_valid  <= 1'b0;
      id_pred   <= 1'b0;
      id_idx    <= '0;
      id_target <= '0;
      id_fall   <= '0;
    end else if (IF_ID_Write) begin
      // The IF slot is wrong-path during a mispredict and is never made valid.
      id_valid  <= if_is_branch & ~Mispredict & ~ID_Flush;
      id_pred   <= PredictTaken;
      id_idx    <= if_idx;
      id_target <= if_target;
      id_fall   <= if_fall;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StatBranches    <= '0;
      StatMispredicts <= '0;
    end else begin
      if (resolve)    StatBranches    <= StatBranches + 32'd1;
      if (Mispredict) StatMispredicts <= StatMispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference model feeds an expected
// queue each cycle; directed test-plan cases followed by a random phase.
module tb_branch_predictor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_ID_Write;
  logic        ID_Flush;
  logic        ID_BranchTaken;
  logic        PredictTaken;
  logic [31:0] PredictedPC;
  logic        Mispredict;
  logic [31:0] CorrectPC;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] StatBranches;
  logic [31:0] StatMispredicts;
`endif

  branch_predictor dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .IF_PC          (IF_PC),
    .IF_Instruction (IF_Instruction),
    .IF_ID_Write    (IF_ID_Write),
    .ID_Flush       (ID_Flush),
    .ID_BranchTaken (ID_BranchTaken),
    .PredictTaken   (PredictTaken),
    .PredictedPC    (PredictedPC),
    .Mispredict     (Mispredict),
`ifdef BRANCH_PRED_STATS_EN
    .StatBranches   (StatBranches),
    .StatMispredicts(StatMispredicts),
`endif
    .CorrectPC      (CorrectPC)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [1:0]  ref_ctr [64];
  logic        m_valid = 1'b0;
  logic        m_pred  = 1'b0;
  logic [5:0]  m_idx   = '0;
  logic [31:0] m_tgt   = '0;
  logic [31:0] m_fall  = '0;
  logic [31:0] m_br    = '0;
  logic [31:0] m_mp    = '0;
  logic [65:0] exp_q [$];

  // last sampled outputs, for directed checks
  logic        s_pt, s_misp;
  logic [31:0] s_ppc, s_cpc;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] ADD = 32'h0022_1820;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic m_is_branch(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'h04 || op == 6'h05 || op == 6'h06 || op == 6'h07) return 1'b1;
    if (op == 6'h01) return (i[20:16] == 5'd0) || (i[20:16] == 5'd1);
    return 1'b0;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // driver + scoreboard: one call = one clock cycle
  task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic wr,
                      input logic flush, input logic taken, input logic rst_v, input string tag);
    logic        isb, e_pt, e_misp, res;
    logic [31:0] tgt, fall, e_ppc, e_cpc;
    logic [65:0] e;
    IF_PC = pc; IF_Instruction = instr; IF_ID_Write = wr;
    ID_Flush = flush; ID_BranchTaken = taken; Rst = rst_v;
    isb    = m_is_branch(instr);
    fall   = pc + 32'd4;
    tgt    = fall + {{14{instr[15]}}, instr[15:0], 2'b00};
    e_pt   = !rst_v && isb && ref_ctr[pc[7:2]][1];
    e_ppc  = e_pt ? tgt : fall;
    res    = !rst_v && m_valid && wr;
    e_misp = res && (m_pred != taken);
    e_cpc  = taken ? m_tgt : m_fall;
    exp_q.push_back({e_pt, e_ppc, e_misp, e_cpc});
    #2;
    e = exp_q.pop_front();
    s_pt = PredictTaken; s_ppc = PredictedPC; s_misp = Mispredict; s_cpc = CorrectPC;
    check({tag, ".pt"},   {31'd0, PredictTaken}, {31'd0, e[65]});
    check({tag, ".ppc"},  PredictedPC, e[64:33]);
    check({tag, ".misp"}, {31'd0, Mispredict}, {31'd0, e[32]});
    if (e[32]) check({tag, ".cpc"}, CorrectPC, e[31:0]);
    @(posedge Clk);
    if (rst_v) begin
      for (int i = 0; i < 64; i++) ref_ctr[i] = 2'b01;
      m_valid = 1'b0; m_br = '0; m_mp = '0;
    end else begin
      if (res) begin
        m_br++;
        if (e_misp) m_mp++;
        if (taken && ref_ctr[m_idx] != 2'b11) ref_ctr[m_idx] = ref_ctr[m_idx] + 2'd1;
        else if (!taken && ref_ctr[m_idx] != 2'b00) ref_ctr[m_idx] = ref_ctr[m_idx] - 2'd1;
      end
      if (wr) begin
        m_valid = isb && !e_misp && !flush;
        m_pred = e_pt; m_idx = pc[7:2]; m_tgt = tgt; m_fall = fall;
      end
    end
    #1;
  endtask

  task automatic check_ctrs(input string tag);
    for (int i = 0; i < 64; i++) check(tag, {30'd0, dut.u_table.ctr[i]}, {30'd0, ref_ctr[i]});
  endtask

  initial begin
    logic [31:0] beq4, pc, instr;
    logic [31:0] br_list [4];
    for (int i = 0; i < 64; i++) ref_ctr[i] = 2'b01;
    beq4 = mk(6'h04, 5'd2, 16'h0004);

    // reset: quiet outputs, all counters weakly not-taken
    for (int i = 0; i < 3; i++) step(32'h0040_0010, beq4, 1'b1, 1'b0, 1'b1, 1'b1, "rst");
    check("rst_pt", {31'd0, s_pt}, 32'd0);
    for (int i = 0; i < 64; i++) check("rst_ctr", {30'd0, dut.u_table.ctr[i]}, 32'd1);

    // first beq: predicted NT, resolved taken
    step(32'h0040_0010, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "beq1");
    check("beq1_pt", {31'd0, s_pt}, 32'd0);
    check("beq1_ppc", s_ppc, 32'h0040_0014);
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "beq1_res");
    check("beq1_misp", {31'd0, s_misp}, 32'd1);
    check("beq1_cpc", s_cpc, 32'h0040_0024);
    check("beq1_ctr", {30'd0, dut.u_table.ctr[4]}, 32'd2);

    // second and third beq: predicted taken, saturates at 11
    step(32'h0040_0010, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "beq2");
    check("beq2_pt", {31'd0, s_pt}, 32'd1);
    check("beq2_ppc", s_ppc, 32'h0040_0024);
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "beq2_res");
    check("beq2_misp", {31'd0, s_misp}, 32'd0);
    check("beq2_ctr", {30'd0, dut.u_table.ctr[4]}, 32'd3);
    step(32'h0040_0010, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "beq3");
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "beq3_res");
    check("beq3_ctr", {30'd0, dut.u_table.ctr[4]}, 32'd3);

    // negative offset and PC wrap
    step(32'h0040_0000, mk(6'h05, 5'd2, 16'hFFFF), 1'b1, 1'b0, 1'b0, 1'b0, "bne");
    check("bne_ppc", s_ppc, 32'h0040_0004);
    step(32'h0040_0004, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "bne_res");
    check("bne_cpc", s_cpc, 32'h0040_0000);
    step(32'hFFFF_FFFC, mk(6'h04, 5'd2, 16'h0000), 1'b1, 1'b0, 1'b0, 1'b0, "wrap");
    check("wrap_ppc", s_ppc, 32'h0000_0000);
    step(32'h0000_0000, NOP, 1'b1, 1'b0, 1'b0, 1'b0, "wrap_res");
    check("wrap_ctr", {30'd0, dut.u_table.ctr[63]}, 32'd0);

    // stall: branch held in ID for three cycles, one update on release
    step(32'h0040_0020, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "stall_ld");
    for (int i = 0; i < 3; i++) begin
      step(32'h0040_0024, NOP, 1'b0, 1'b0, 1'b1, 1'b0, "stall");
      check("stall_misp", {31'd0, s_misp}, 32'd0);
    end
    check("stall_ctr", {30'd0, dut.u_table.ctr[8]}, 32'd1);
    step(32'h0040_0024, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "stall_rel");
    check("stall_rel_misp", {31'd0, s_misp}, 32'd1);
    check("stall_rel_cpc", s_cpc, 32'h0040_0034);
    step(32'h0040_0028, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "stall_post");
    check("stall_ctr_once", {30'd0, dut.u_table.ctr[8]}, 32'd2);

    // mispredict with a same-index branch in IF: old counter, not made valid
    step(32'h0040_0020, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "same_ld");
    step(32'h0040_0020, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "same_mp");
    check("same_pt_old", {31'd0, s_pt}, 32'd1);
    check("same_misp", {31'd0, s_misp}, 32'd1);
    check("same_cpc", s_cpc, 32'h0040_0024);
    step(32'h0040_0024, NOP, 1'b1, 1'b0, 1'b0, 1'b0, "same_next");
    check("same_next_misp", {31'd0, s_misp}, 32'd0);
    check("same_ctr", {30'd0, dut.u_table.ctr[8]}, 32'd1);

    // external flush squashes the IF slot
    step(32'h0040_0010, beq4, 1'b1, 1'b1, 1'b0, 1'b0, "flush");
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b0, 1'b0, "flush_next");
    check("flush_misp", {31'd0, s_misp}, 32'd0);

    // non-branches never predicted or resolved; every branch form decodes
    step(32'h0040_0010, ADD, 1'b1, 1'b0, 1'b0, 1'b0, "add");
    check("add_pt", {31'd0, s_pt}, 32'd0);
    step(32'h0040_0010, mk(6'h01, 5'd2, 16'h0010), 1'b1, 1'b0, 1'b1, 1'b0, "regimm2");
    check("regimm2_pt", {31'd0, s_pt}, 32'd0);
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b0, 1'b0, "regimm2_res");
    check("regimm2_misp", {31'd0, s_misp}, 32'd0);
    br_list[0] = mk(6'h01, 5'd0, 16'h0008);
    br_list[1] = mk(6'h01, 5'd1, 16'h0008);
    br_list[2] = mk(6'h06, 5'd0, 16'h0008);
    br_list[3] = mk(6'h07, 5'd0, 16'h0008);
    for (int i = 0; i < 4; i++) begin
      step(32'h0040_0010, br_list[i], 1'b1, 1'b0, 1'b1, 1'b0, "brform");
      check("brform_pt", {31'd0, s_pt}, 32'd1);
      step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b1, 1'b0, "brform_res");
    end

    // reset with a mispredict pending
    step(32'h0040_0010, beq4, 1'b1, 1'b0, 1'b0, 1'b0, "rp_ld");
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b0, 1'b1, "rp_rst");
    check("rp_rst_misp", {31'd0, s_misp}, 32'd0);
    step(32'h0040_0014, NOP, 1'b1, 1'b0, 1'b0, 1'b0, "rp_after");
    check("rp_after_misp", {31'd0, s_misp}, 32'd0);
    for (int i = 0; i < 64; i++) check("rp_ctr", {30'd0, dut.u_table.ctr[i]}, 32'd1);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      pc = 32'h0040_0000 + ($urandom_range(0, 15) << 2);
      case ($urandom_range(0, 7))
        0: instr = mk(6'h04, 5'd2, 16'($urandom_range(0, 65535)));
        1: instr = mk(6'h05, 5'd2, 16'($urandom_range(0, 65535)));
        2: instr = mk(6'h06, 5'd0, 16'($urandom_range(0, 65535)));
        3: instr = mk(6'h07, 5'd0, 16'($urandom_range(0, 65535)));
        4: instr = mk(6'h01, 5'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
        5: instr = ADD;
        default: instr = $urandom;
      endcase
      step(pc, instr, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, "rnd");
    end
    check_ctrs("rnd_ctr");
`ifdef BRANCH_PRED_STATS_EN
    check("stat_br", StatBranches, m_br);
    check("stat_mp", StatMispredicts, m_mp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage MIPS pipeline.
- Sits in IF and consumes the ID-stage branch resolution produced by the branch comparator.
- Predicts taken/not-taken in IF from a table of 2-bit saturating counters indexed by PC, and steers the next PC.
- Carries the prediction into ID, checks it against the resolved outcome, requests an IF flush plus a PC correction on mispredict, and trains the counter.

Parameters:
INDEX_BITS, 6, log2 of counter-table entries (64 entries), indexed by PC[INDEX_BITS+1:2]
INIT_STATE, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  synchronous active-high reset
IF_PC  input  32  PC of instruction in IF
IF_Instruction  input  32  instruction fetched in IF
IF_ID_Write  input  1  IF/ID register enable; 0 = stall (from hazard unit)
ID_Flush  input  1  external squash of the IF/ID slot (jumps)
ID_BranchTaken  input  1  resolved outcome from the branch comparator for the instruction in ID
PredictTaken  output  1  IF-stage prediction
PredictedPC  output  32  next PC requested by the predictor (target or PC+4)
Mispredict  output  1  ID-stage mispredict; flushes IF and overrides the PC mux
CorrectPC  output  32  PC to fetch on mispredict

Behaviour:
- Branch decode (IF): opcode 000100 beq, 000101 bne, 000110 blez, 000111 bgtz; opcode 000001 with Instruction[20:16] = 00000 (bltz) or 00001 (bgez). Every other encoding is not a branch.
- Target = IF_PC + 4 + (sign-extended Instruction[15:0] << 2), 32-bit modulo; wrap-around is ignored. Fallthrough = IF_PC + 4.
- PredictTaken = IsBranch & counter[idx][1]. PredictedPC = PredictTaken ? Target : Fallthrough. Both are combinational, with zero latency.
- ID pipeline register holds: Valid, PredTaken, Index, Target, Fallthrough.
  - Load on rising edge when IF_ID_Write = 1. Valid = IsBranch & ~Mispredict & ~ID_Flush.
  - Hold when IF_ID_Write = 0. A stalled branch is resolved only once the stall releases.
  - Rst or (ID_Flush with IF_ID_Write = 1) clears Valid.
- Resolve (ID): Resolve = Valid & IF_ID_Write.
  - Mispredict = Resolve & (PredTaken != ID_BranchTaken).
  - CorrectPC = ID_BranchTaken ? Target : Fallthrough. Value is don't-care when Mispredict = 0; drive Fallthrough.
- Counter update on Resolve, at the rising edge: taken increments and saturates at 11; not-taken decrements and saturates at 00. Exactly one update per valid branch.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is bit [1].
- Same-index read/write in one cycle: the IF lookup sees the pre-update value. No bypass.
- Mispredict takes priority over PredictedPC at the top-level PC mux. The IF instruction in that cycle is wrong-path and is not registered as Valid.
- Reset:
  - All counters load INIT_STATE; Valid = 0.
  - Mispredict = 0 and PredictTaken = 0 while Rst is high (table reads as not-taken).
  - Reset mid-stall discards the pending branch with no update.

Optional Feature:
BRANCH_PRED_STATS_EN
- Defined: adds outputs StatBranches[31:0] and StatMispredicts[31:0].
  - StatBranches increments on every Resolve; StatMispredicts increments on every Mispredict.
  - Both clear on Rst and wrap at 2^32.
- Undefined: counters and ports are absent, and predictor behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM; RT_BLTZ, RT_BGEZ.
  - Counter state localparams SNT, WNT, WT, ST.
  - Function is_branch(instr).
- Sub-module sat_counter_table: counter array with async read port, one synchronous write port (index, taken, enable) and reset init. The top level holds decode, the ID register and resolve logic.

Test Plan:
- Reset, then beq at PC 0x00400010 with imm 0x0004 -> PredictTaken = 0, PredictedPC = 0x00400014; ID_BranchTaken = 1 -> Mispredict = 1, CorrectPC = 0x00400024, counter 01->10.
- Same beq again -> PredictTaken = 1, PredictedPC = 0x00400024; resolve taken -> Mispredict = 0, counter 10->11; third taken keeps 11 (saturation).
- bne with imm 0xFFFF at PC 0x00400000 -> target 0x00400000 (negative offset); at PC 0xFFFFFFFC, imm 0 -> fallthrough 0x00000000 (wrap).
- Branch in ID with IF_ID_Write = 0 for 3 cycles -> no Mispredict and no counter change until release, then exactly one update.
- Mispredict cycle with a branch in IF at the same index -> IF lookup uses the old counter, and the IF branch is not Valid in ID next cycle; add/sub (opcode 000000) and regimm rt = 00010 -> never predicted, never resolved.
- Rst asserted while Valid = 1 and a mispredict is pending -> Mispredict = 0 next cycle; all counters read 01.
